// File: rtl/btn_pulse_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : btn_pulse_gen_if
// Description : Button pin and event pulse bundle for btn_pulse_gen.
//               'slave' is the conditioner's view, 'master' the user's view.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface btn_pulse_gen_if;
  logic btn_raw;        // raw asynchronous button, 1 = pressed
  logic btn_level;      // debounced button level
  logic press_pulse;    // one-cycle pulse on accepted press
  logic release_pulse;  // one-cycle pulse on accepted release
  logic long_pulse;     // one-cycle pulse when held long enough

  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface
`default_nettype wire

// File: rtl/btn_pulse_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : btn_pulse_gen
// Description : Synchronises and debounces a mechanical push-button and
//               produces a debounced level plus registered one-cycle press,
//               release and long-press pulses.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 20,
  parameter int CNT_W           = 8
) (
  input  wire             clk,
  input  wire             rst,
  btn_pulse_gen_if.slave  btn_io
);

  localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_max  = CNT_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             btn_level_q, btn_level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             w_btn_s;

  assign w_btn_s = s2_q;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_io.btn_raw;
      s2_q <= s1_q;
    end
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      btn_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      btn_level_q <= btn_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  // Next-state, counter and pulse decode; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    btn_level_d = btn_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        btn_level_d = 1'b0;
        if (w_btn_s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = CNT_W'(1);
        end else begin
          dcnt_d = '0;
          hcnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!w_btn_s) begin
          // Too short to be a press: drop it silently.
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == c_deb_last) begin
          state_d     = HELD;
          press_d     = 1'b1;
          btn_level_d = 1'b1;
          dcnt_d      = '0;
          hcnt_d      = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      HELD: begin
        if (!w_btn_s) begin
          // Hold time freezes while a possible release is being qualified.
          state_d = RELEASE_WAIT;
          dcnt_d  = CNT_W'(1);
        end else if (hcnt_q == c_long_last) begin
          long_d = 1'b1;
          hcnt_d = c_long_max;
        end else if (hcnt_q < c_long_max) begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      RELEASE_WAIT: begin
        if (w_btn_s) begin
          // Release bounce: back to held. The hold count resumes on this
          // edge so the long pulse slips by exactly the cycles spent low.
          state_d = HELD;
          dcnt_d  = '0;
          if (hcnt_q == c_long_last) begin
            long_d = 1'b1;
            hcnt_d = c_long_max;
          end else if (hcnt_q < c_long_max) begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else if (dcnt_q == c_deb_last) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          btn_level_d = 1'b0;
          dcnt_d      = '0;
          hcnt_d      = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        dcnt_d      = '0;
        hcnt_d      = '0;
        btn_level_d = 1'b0;
      end
    endcase
  end

  assign btn_io.btn_level     = btn_level_q;
  assign btn_io.press_pulse   = press_q;
  assign btn_io.release_pulse = release_q;
  assign btn_io.long_pulse    = long_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_btn_pulse_gen
// Description : Scoreboard bench for btn_pulse_gen (DEBOUNCE=4, LONG=20).
//               Expected pulse kind/cycle pairs are queued when stimulus is
//               driven and popped as the DUT raises pulses.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_btn_pulse_gen;

  localparam int c_press = 1;
  localparam int c_rel   = 2;
  localparam int c_long  = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  sb[$];

  // Downstream toggle FSM model: 0 = pause, 1 = count.
  logic tog_q;
  int   toggles;

  btn_pulse_gen_if ifc ();

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .CNT_W          (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_io (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: at a falling edge it equals the rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q   <= 1'b0;
      toggles <= 0;
    end else if (ifc.press_pulse) begin
      tog_q   <= ~tog_q;
      toggles <= toggles + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_pulse", kind, 0);
    end else begin
      e = sb.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.cyc);
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.press_pulse && ifc.release_pulse) chk("press_rel_excl", 1, 0);
      if (ifc.press_pulse)   take(c_press);
      if (ifc.release_pulse) take(c_rel);
      if (ifc.long_pulse)    take(c_long);
    end
  end

  initial begin
    int c;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    ifc.btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level",   ifc.btn_level, 0);
    chk("rst_press",   ifc.press_pulse, 0);
    chk("rst_release", ifc.release_pulse, 0);
    chk("rst_long",    ifc.long_pulse, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: clean press, 10 cycles
    c = cyc;
    ifc.btn_raw = 1'b1;
    push(c_press, c + 6);
    step_to(c + 5);  chk("t1_level_pre", ifc.btn_level, 0);
    step_to(c + 6);  chk("t1_level_on", ifc.btn_level, 1);
    step_to(c + 10); ifc.btn_raw = 1'b0; push(c_rel, c + 16);
    step_to(c + 15); chk("t1_level_hold", ifc.btn_level, 1);
    step_to(c + 16); chk("t1_level_off", ifc.btn_level, 0);
    step_to(c + 22); chk("t1_sb_empty", sb.size(), 0);

    // 2: 3-cycle glitch rejected
    c = cyc;
    ifc.btn_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step_to(c + k);
      if (k == 3) ifc.btn_raw = 1'b0;
      chk("t2_level", ifc.btn_level, 0);
    end
    chk("t2_sb_empty", sb.size(), 0);

    // 3: long press, 40 cycles
    c = cyc;
    ifc.btn_raw = 1'b1;
    push(c_press, c + 6);
    push(c_long, c + 26);
    step_to(c + 40); ifc.btn_raw = 1'b0; push(c_rel, c + 46);
    step_to(c + 45); chk("t3_level_hold", ifc.btn_level, 1);
    step_to(c + 50); chk("t3_level_off", ifc.btn_level, 0);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: release bounce of 2 cycles while held
    c = cyc;
    ifc.btn_raw = 1'b1;
    push(c_press, c + 6);
    push(c_long, c + 28);
    for (int k = 6; k <= 39; k++) begin
      step_to(c + k);
      chk("t4_level", ifc.btn_level, 1);
      if (k == 10) ifc.btn_raw = 1'b0;
      if (k == 12) ifc.btn_raw = 1'b1;
    end
    step_to(c + 40); ifc.btn_raw = 1'b0; push(c_rel, c + 46);
    step_to(c + 50); chk("t4_sb_empty", sb.size(), 0);

    // 5: async reset mid-hold
    c = cyc;
    ifc.btn_raw = 1'b1;
    push(c_press, c + 6);
    step_to(c + 10);
    rst = 1'b1;
    #1;
    chk("t5_rst_level",   ifc.btn_level, 0);
    chk("t5_rst_press",   ifc.press_pulse, 0);
    chk("t5_rst_release", ifc.release_pulse, 0);
    chk("t5_rst_long",    ifc.long_pulse, 0);
    step_to(c + 12); chk("t5_rst_level2", ifc.btn_level, 0);
    step_to(c + 13); rst = 1'b0; push(c_press, c + 19);
    step_to(c + 18); chk("t5_level_pre", ifc.btn_level, 0);
    step_to(c + 19); chk("t5_level_on", ifc.btn_level, 1);
    step_to(c + 25); ifc.btn_raw = 1'b0; push(c_rel, c + 31);
    step_to(c + 35); chk("t5_sb_empty", sb.size(), 0);

    // 6: three presses drive the pause/count toggle FSM
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      ifc.btn_raw = 1'b1;
      push(c_press, c + 6);
      step_to(c + 10); ifc.btn_raw = 1'b0; push(c_rel, c + 16);
      step_to(c + 22);
    end
    chk("t6_toggles", toggles, 3);
    chk("t6_count_state", tog_q, 1);
    chk("t6_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
